// File: rtl/arm_banked_regfile.sv
// rtl/arm_banked_regfile.sv - ARMv4T banked GPR/CPSR/SPSR file with exception entry (optional ARM_REGFILE_BYPASS_EN)
module arm_banked_regfile #(
  parameter int          DATA_W     = 32,
  parameter logic [4:0]  RESET_MODE = 5'b10011,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  input  logic [3:0]        rd_addr_c,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic              rd_user,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_user,
  output logic [DATA_W-1:0] pc_out,
  output logic [31:0]       cpsr_out,
  input  logic              cpsr_wr_en,
  input  logic              spsr_wr_en,
  input  logic [31:0]       psr_wr_data,
  input  logic [3:0]        psr_wr_mask,
  output logic [31:0]       spsr_out,
  input  logic              exc_req,
  input  logic [4:0]        exc_mode,
  input  logic [DATA_W-1:0] exc_lr,
  output logic              exc_ack
);

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;
  localparam logic [4:0] M_SYS = 5'b11111;

  // Physical map: 0-7 shared, 8-14 USR R8-R14, 15-21 FIQ R8-R14,
  // 22/23 IRQ, 24/25 SVC, 26/27 ABT, 28/29 UND R13/R14, 30 = R15.
  logic [DATA_W-1:0] gpr [0:30];
  logic [31:0]       cpsr;
  logic [31:0]       spsr [0:4];

  function automatic logic is_exc_mode(input logic [4:0] m);
    return (m == M_FIQ) || (m == M_IRQ) || (m == M_SVC) || (m == M_ABT) || (m == M_UND);
  endfunction

  function automatic logic is_valid_mode(input logic [4:0] m);
    return is_exc_mode(m) || (m == M_USR) || (m == M_SYS);
  endfunction

  function automatic logic [2:0] spsr_sel(input logic [4:0] m);
    logic [2:0] s;
    case (m)
      M_FIQ:   s = 3'd0;
      M_IRQ:   s = 3'd1;
      M_SVC:   s = 3'd2;
      M_ABT:   s = 3'd3;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

  function automatic logic [4:0] phys_idx(input logic [4:0] mode, input logic [3:0] a,
                                          input logic usr);
    logic [4:0] m;
    logic [4:0] idx;
    m = usr ? M_USR : mode;
    if (a < 4'd8)            idx = {1'b0, a};
    else if (a == 4'd15)     idx = 5'd30;
    else if (m == M_FIQ)     idx = {1'b0, a} + 5'd7;
    else if (a < 4'd13)      idx = {1'b0, a};
    else begin
      case (m)
        M_IRQ:   idx = 5'd22;
        M_SVC:   idx = 5'd24;
        M_ABT:   idx = 5'd26;
        M_UND:   idx = 5'd28;
        default: idx = 5'd13;
      endcase
      if (a == 4'd14) idx = idx + 5'd1;
    end
    return idx;
  endfunction

  logic [4:0]  cur_mode;
  logic        cur_priv;
  logic        cur_has_spsr;
  logic [2:0]  cur_spsr;
  logic        exc_take;
  logic [4:0]  exc_r14;
  logic [4:0]  wr_idx;
  logic [4:0]  idx_a, idx_b, idx_c;
  logic [31:0] cpsr_msr, spsr_msr, cpsr_exc;

  assign cur_mode     = cpsr[4:0];
  assign cur_priv     = is_valid_mode(cur_mode) && (cur_mode != M_USR);
  assign cur_has_spsr = is_exc_mode(cur_mode);
  assign cur_spsr     = spsr_sel(cur_mode);
  assign exc_take     = exc_req && is_exc_mode(exc_mode);
  assign exc_r14      = phys_idx(exc_mode, 4'd14, 1'b0);
  assign wr_idx       = phys_idx(cur_mode, wr_addr, wr_user);
  assign idx_a        = phys_idx(cur_mode, rd_addr_a, rd_user);
  assign idx_b        = phys_idx(cur_mode, rd_addr_b, rd_user);
  assign idx_c        = phys_idx(cur_mode, rd_addr_c, rd_user);

  function automatic logic [DATA_W-1:0] rd_val(input logic [4:0] idx);
`ifdef ARM_REGFILE_BYPASS_EN
    if (exc_take && idx == exc_r14)  return exc_lr;
    else if (wr_en && idx == wr_idx) return wr_data;
    else                             return gpr[idx];
`else
    return gpr[idx];
`endif
  endfunction

  assign rd_data_a = rd_val(idx_a);
  assign rd_data_b = rd_val(idx_b);
  assign rd_data_c = rd_val(idx_c);
  assign pc_out    = gpr[30];
  assign cpsr_out  = cpsr;
  assign spsr_out  = cur_has_spsr ? spsr[cur_spsr] : 32'h0;

  // MSR and exception-entry next values for the PSRs
  always_comb begin
    cpsr_msr = cpsr;
    if (psr_wr_mask[3]) cpsr_msr[31:24] = psr_wr_data[31:24];
    if (psr_wr_mask[0] && cur_priv) begin
      cpsr_msr[7:5] = psr_wr_data[7:5];
      if (is_valid_mode(psr_wr_data[4:0])) cpsr_msr[4:0] = psr_wr_data[4:0];
    end
    spsr_msr = spsr[cur_spsr];
    if (psr_wr_mask[3]) spsr_msr[31:24] = psr_wr_data[31:24];
    if (psr_wr_mask[0]) spsr_msr[7:0]   = psr_wr_data[7:0];
    cpsr_exc = {cpsr[31:8], 1'b1, (exc_mode == M_FIQ) ? 1'b1 : cpsr[6], 1'b0, exc_mode};
  end

  // GPR writes; exception link write is last so it wins a same-register collision
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) gpr[i] <= '0;
      gpr[30] <= DATA_W'(RESET_PC);
    end else begin
      if (wr_en)    gpr[wr_idx]  <= wr_data;
      if (exc_take) gpr[exc_r14] <= exc_lr;
    end
  end

  // CPSR/SPSR update; exception entry pre-empts MSR on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpsr <= {24'h0, 1'b1, 1'b1, 1'b0, RESET_MODE};
      for (int i = 0; i < 5; i++) spsr[i] <= '0;
    end else if (exc_take) begin
      cpsr                <= cpsr_exc;
      spsr[spsr_sel(exc_mode)] <= cpsr;
    end else begin
      if (cpsr_wr_en)                 cpsr           <= cpsr_msr;
      if (spsr_wr_en && cur_has_spsr) spsr[cur_spsr] <= spsr_msr;
    end
  end

  // Acknowledge pulse one cycle after each accepted entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) exc_ack <= 1'b0;
    else       exc_ack <= exc_take;
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, psr_wr_mask[2:1], psr_wr_data[23:8]};

endmodule

// File: tb/tb_arm_banked_regfile.sv
// tb/tb_arm_banked_regfile.sv - self-checking bench for arm_banked_regfile
module tb_arm_banked_regfile;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rd_addr_a = '0, rd_addr_b = '0, rd_addr_c = '0;
  logic [31:0] rd_data_a, rd_data_b, rd_data_c;
  logic        rd_user = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_user = 1'b0;
  logic [31:0] pc_out, cpsr_out, spsr_out;
  logic        cpsr_wr_en = 1'b0, spsr_wr_en = 1'b0;
  logic [31:0] psr_wr_data = '0;
  logic [3:0]  psr_wr_mask = '0;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_mode = '0;
  logic [31:0] exc_lr = '0;
  logic        exc_ack;

  arm_banked_regfile dut (
    .clock(clock), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
    .rd_user(rd_user), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_user(wr_user), .pc_out(pc_out), .cpsr_out(cpsr_out),
    .cpsr_wr_en(cpsr_wr_en), .spsr_wr_en(spsr_wr_en),
    .psr_wr_data(psr_wr_data), .psr_wr_mask(psr_wr_mask), .spsr_out(spsr_out),
    .exc_req(exc_req), .exc_mode(exc_mode), .exc_lr(exc_lr), .exc_ack(exc_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;  logic [3:0] wa; logic [31:0] wd; logic wu;
    logic        cwe; logic swe; logic [31:0] pd; logic [3:0] pm;
    logic        ex;  logic [4:0] em; logic [31:0] el;
    logic [3:0]  ra;  logic ru;
    logic [31:0] e_rd; logic [31:0] e_cpsr; logic [31:0] e_spsr; logic e_ack;
  } vec_t;

  typedef struct {
    logic [31:0] rd; logic [31:0] cpsr; logic [31:0] spsr; logic ack;
  } exp_t;

  vec_t vecs [0:21];
  exp_t sb [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic wu, input logic cwe, input logic swe,
                              input logic [31:0] pd, input logic [3:0] pm, input logic ex,
                              input logic [4:0] em, input logic [31:0] el, input logic [3:0] ra,
                              input logic ru, input logic [31:0] e_rd, input logic [31:0] e_cpsr,
                              input logic [31:0] e_spsr, input logic e_ack);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.wu = wu; v.cwe = cwe; v.swe = swe; v.pd = pd;
    v.pm = pm; v.ex = ex; v.em = em; v.el = el; v.ra = ra; v.ru = ru; v.e_rd = e_rd;
    v.e_cpsr = e_cpsr; v.e_spsr = e_spsr; v.e_ack = e_ack;
    return v;
  endfunction

  initial begin
    exp_t e;
    //            we wa    wd        wu cwe swe pd            pm      ex em       el        ra    ru e_rd      e_cpsr        e_spsr        ack
    vecs[0]  = mk(1, 4'd13, 32'h1111, 0, 0, 0, 32'h0,        4'b0000, 0, 5'h00, 32'h0,   4'd13, 0, 32'h1111, 32'h000000D3, 32'h0,        0);
    vecs[1]  = mk(0, 4'd0,  32'h0,    0, 1, 0, 32'h000000D1, 4'b0001, 0, 5'h00, 32'h0,   4'd13, 0, 32'h0,    32'h000000D1, 32'h0,        0);
    vecs[2]  = mk(1, 4'd13, 32'h2222, 0, 0, 0, 32'h0,        4'b0000, 0, 5'h00, 32'h0,   4'd13, 0, 32'h2222, 32'h000000D1, 32'h0,        0);
    vecs[3]  = mk(1, 4'd8,  32'hAAAA, 0, 0, 0, 32'h0,        4'b0000, 0, 5'h00, 32'h0,   4'd8,  0, 32'hAAAA, 32'h000000D1, 32'h0,        0);
    vecs[4]  = mk(1, 4'd8,  32'hBBBB, 1, 0, 0, 32'h0,        4'b0000, 0, 5'h00, 32'h0,   4'd8,  1, 32'hBBBB, 32'h000000D1, 32'h0,        0);
    vecs[5]  = mk(0, 4'd0,  32'h0,    0, 0, 0, 32'h0,        4'b0000, 0, 5'h00, 32'h0,   4'd8,  0, 32'hAAAA, 32'h000000D1, 32'h0,        0);
    vecs[6]  = mk(0, 4'd0,  32'h0,    0, 0, 0, 32'h0,        4'b0000, 0, 5'h00, 32'h0,   4'd13, 1, 32'h0,    32'h000000D1, 32'h0,        0);
    vecs[7]  = mk(0, 4'd0,  32'h0,    0, 1, 0, 32'h600000D3, 4'b1001, 0, 5'h00, 32'h0,   4'd13, 0, 32'h1111, 32'h600000D3, 32'h0,        0);
    vecs[8]  = mk(0, 4'd0,  32'h0,    0, 0, 0, 32'h0,        4'b0000, 1, 5'h12, 32'h104, 4'd14, 0, 32'h104,  32'h600000D2, 32'h600000D3, 1);
    vecs[9]  = mk(0, 4'd0,  32'h0,    0, 0, 0, 32'h0,        4'b0000, 0, 5'h00, 32'h0,   4'd14, 0, 32'h104,  32'h600000D2, 32'h600000D3, 0);
    vecs[10] = mk(0, 4'd0,  32'h0,    0, 0, 1, 32'h12345678, 4'b1001, 0, 5'h00, 32'h0,   4'd0,  0, 32'h0,    32'h600000D2, 32'h12000078, 0);
    vecs[11] = mk(0, 4'd0,  32'h0,    0, 1, 0, 32'h00000010, 4'b0001, 0, 5'h00, 32'h0,   4'd8,  0, 32'hBBBB, 32'h60000010, 32'h0,        0);
    vecs[12] = mk(0, 4'd0,  32'h0,    0, 1, 0, 32'hF00000D3, 4'b1001, 0, 5'h00, 32'h0,   4'd13, 0, 32'h0,    32'hF0000010, 32'h0,        0);
    vecs[13] = mk(0, 4'd0,  32'h0,    0, 0, 1, 32'hFFFFFFFF, 4'b1111, 0, 5'h00, 32'h0,   4'd13, 0, 32'h0,    32'hF0000010, 32'h0,        0);
    vecs[14] = mk(0, 4'd0,  32'h0,    0, 0, 0, 32'h0,        4'b0000, 1, 5'h13, 32'h200, 4'd14, 0, 32'h200,  32'hF0000093, 32'hF0000010, 1);
    vecs[15] = mk(1, 4'd14, 32'h5555, 0, 1, 0, 32'h0000001F, 4'b1111, 1, 5'h11, 32'h300, 4'd14, 0, 32'h300,  32'hF00000D1, 32'hF0000093, 1);
    vecs[16] = mk(0, 4'd0,  32'h0,    0, 1, 0, 32'h000000D3, 4'b0001, 0, 5'h00, 32'h0,   4'd14, 0, 32'h5555, 32'hF00000D3, 32'hF0000010, 0);
    vecs[17] = mk(0, 4'd0,  32'h0,    0, 1, 0, 32'h0000003A, 4'b0001, 0, 5'h00, 32'h0,   4'd14, 0, 32'h5555, 32'hF0000033, 32'hF0000010, 0);
    vecs[18] = mk(0, 4'd0,  32'h0,    0, 0, 0, 32'h0,        4'b0000, 1, 5'h10, 32'hDEAD,4'd14, 0, 32'h5555, 32'hF0000033, 32'hF0000010, 0);
    vecs[19] = mk(1, 4'd14, 32'h7777, 0, 0, 0, 32'h0,        4'b0000, 1, 5'h13, 32'h400, 4'd14, 0, 32'h400,  32'hF0000093, 32'hF0000033, 1);
    vecs[20] = mk(1, 4'd15, 32'h1000, 0, 0, 0, 32'h0,        4'b0000, 0, 5'h00, 32'h0,   4'd15, 0, 32'h1000, 32'hF0000093, 32'hF0000033, 0);
    vecs[21] = mk(0, 4'd0,  32'h0,    0, 0, 0, 32'h0,        4'b0000, 1, 5'h15, 32'h1,   4'd14, 0, 32'h400,  32'hF0000093, 32'hF0000033, 0);

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    rd_addr_a = 4'd15; rd_addr_b = 4'd13; rd_addr_c = 4'd0;
    #1;
    chk("reset_pc_out", pc_out, 32'h0);
    chk("reset_cpsr_in_reset", cpsr_out, 32'h000000D3);
    reset = 1'b0;
    #1;
    chk("reset_r15", rd_data_a, 32'h0);
    chk("reset_r13", rd_data_b, 32'h0);
    chk("reset_cpsr", cpsr_out, 32'h000000D3);
    chk("reset_spsr", spsr_out, 32'h0);
    chk("reset_ack", {31'h0, exc_ack}, 32'h0);

    // Table-driven vectors through a scoreboard queue
    for (int i = 0; i < 22; i++) begin
      @(negedge clock);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_user = vecs[i].wu;
      cpsr_wr_en = vecs[i].cwe; spsr_wr_en = vecs[i].swe;
      psr_wr_data = vecs[i].pd; psr_wr_mask = vecs[i].pm;
      exc_req = vecs[i].ex; exc_mode = vecs[i].em; exc_lr = vecs[i].el;
      e.rd = vecs[i].e_rd; e.cpsr = vecs[i].e_cpsr; e.spsr = vecs[i].e_spsr; e.ack = vecs[i].e_ack;
      sb.push_back(e);
      @(posedge clock);
      #1;
      wr_en = 1'b0; wr_user = 1'b0; cpsr_wr_en = 1'b0; spsr_wr_en = 1'b0; exc_req = 1'b0;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].ra; rd_addr_c = vecs[i].ra;
      rd_user = vecs[i].ru;
      #1;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty vec=%0d", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_rd_a", i), rd_data_a, e.rd);
        chk($sformatf("v%0d_rd_b", i), rd_data_b, e.rd);
        chk($sformatf("v%0d_rd_c", i), rd_data_c, e.rd);
        chk($sformatf("v%0d_cpsr", i), cpsr_out, e.cpsr);
        chk($sformatf("v%0d_spsr", i), spsr_out, e.spsr);
        chk($sformatf("v%0d_ack", i), {31'h0, exc_ack}, {31'h0, e.ack});
      end
      rd_user = 1'b0;
    end
    chk("pc_out_after_r15_write", pc_out, 32'h1000);

    // Same-cycle write visibility on a read port
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h55; rd_addr_a = 4'd3;
    #1;
`ifdef ARM_REGFILE_BYPASS_EN
    chk("bypass_r3_pre_edge", rd_data_a, 32'h55);
`else
    chk("nobypass_r3_pre_edge", rd_data_a, 32'h0);
`endif
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    #1;
    chk("r3_post_edge", rd_data_a, 32'h55);

    // Reset asserted mid-cycle while an entry is in flight
    @(negedge clock);
    exc_req = 1'b1; exc_mode = 5'b10001; exc_lr = 32'h9;
    @(posedge clock);
    #1;
    chk("pre_reset_ack", {31'h0, exc_ack}, 32'h1);
    chk("pre_reset_cpsr", cpsr_out, 32'hF00000D1);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_cpsr", cpsr_out, 32'h000000D3);
    chk("midreset_ack", {31'h0, exc_ack}, 32'h0);
    chk("midreset_pc", pc_out, 32'h0);
    chk("midreset_spsr", spsr_out, 32'h0);
    @(negedge clock);
    exc_req = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_reset_cpsr", cpsr_out, 32'h000000D3);
    chk("post_reset_ack", {31'h0, exc_ack}, 32'h0);
    rd_addr_a = 4'd14;
    #1;
    chk("post_reset_r14", rd_data_a, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
